// File: rtl/mult_acc_pipe_pkg.sv
// Shared types, latency helper, sign extension and saturation limits for the
// pipelined multiply-accumulate block.
package mult_acc_pkg;

  localparam int MAX_W = 256;

  typedef struct packed {
    logic vld;
    logic asgnd;
    logic bsgnd;
    logic addsub;
    logic lda;
  } ctrl_t;

  function automatic int mac_latency(input int in_reg, input int mul_reg);
    return in_reg + mul_reg + 1;
  endfunction

  // Extends the low w bits of v to MAX_W, replicating bit w-1 only when sgn is set.
  function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] v,
                                                input int w,
                                                input logic sgn);
    logic [MAX_W-1:0] hi_mask;
    logic [MAX_W-1:0] one;
    logic             msb;
    one     = {{(MAX_W-1){1'b0}}, 1'b1};
    hi_mask = {MAX_W{1'b1}} << w;
    msb     = |(v & (one << (w - 1)));
    return (sgn && msb) ? (v | hi_mask) : (v & ~hi_mask);
  endfunction

  function automatic logic [MAX_W-1:0] sat_smax(input int acc_w);
    return ~({MAX_W{1'b1}} << (acc_w - 1));
  endfunction

  function automatic logic [MAX_W-1:0] sat_smin(input int acc_w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (acc_w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_umax(input int acc_w);
    return ~({MAX_W{1'b1}} << acc_w);
  endfunction

endpackage

// File: rtl/mult_acc_pipe_if.sv
// Operand/result bundle of the multiply-accumulate block; the fabric side is
// the master, the MAC itself is the slave.
interface mult_acc_pipe_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 40
);
  logic             IN_VLD;
  logic [A_W-1:0]   A;
  logic [B_W-1:0]   B;
  logic [ACC_W-1:0] C;
  logic             ASGND;
  logic             BSGND;
  logic             ADDSUB;
  logic             LDA;
  logic             HLD;
  logic             OUT_VLD;
  logic [ACC_W-1:0] O;
  logic             OVF;

  modport master (
    output IN_VLD, A, B, C, ASGND, BSGND, ADDSUB, LDA, HLD,
    input  OUT_VLD, O, OVF
  );

  modport slave (
    input  IN_VLD, A, B, C, ASGND, BSGND, ADDSUB, LDA, HLD,
    output OUT_VLD, O, OVF
  );
endinterface

// File: rtl/mult_acc_pipe_satadd.sv
// Combinational ACC_W+1 bit add/subtract with overflow detection and optional
// clamping to the signed or unsigned range of the accumulator.
module mult_acc_satadd
  import mult_acc_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int SAT_EN = 1
) (
  input  logic [ACC_W-1:0] base_i,
  input  logic [ACC_W-1:0] operand_i,
  input  logic             sub_i,
  input  logic             sgnd_i,
  output logic [ACC_W-1:0] result_o,
  output logic             ovf_o
);

  localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_smax(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_smin(ACC_W));
  localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_umax(ACC_W));

  logic [ACC_W:0] base_x;
  logic [ACC_W:0] op_x;
  logic [ACC_W:0] sum_x;
  logic           ovf;

  // The extra top bit is the true sign (signed) or the carry/borrow (unsigned).
  always_comb begin
    base_x   = {sgnd_i & base_i[ACC_W-1], base_i};
    op_x     = {sgnd_i & operand_i[ACC_W-1], operand_i};
    sum_x    = sub_i ? (base_x - op_x) : (base_x + op_x);
    ovf      = sgnd_i ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];
    result_o = sum_x[ACC_W-1:0];
    if (ovf && (SAT_EN != 0)) begin
      if (sgnd_i) begin
        result_o = sum_x[ACC_W] ? SMIN : SMAX;
      end else begin
        result_o = sub_i ? '0 : UMAX;
      end
    end
    ovf_o = ovf;
  end

endmodule

// File: rtl/mult_acc_pipe.sv
// Parametrised pipelined multiply-accumulate: optional input and product
// registers feed a saturating accumulator with a sticky overflow flag.
module mult_acc_pipe
  import mult_acc_pkg::*;
#(
  parameter int A_W     = 16,
  parameter int B_W     = 16,
  parameter int ACC_W   = 40,
  parameter int IN_REG  = 1,
  parameter int MUL_REG = 1,
  parameter int SAT_EN  = 1
) (
  input logic            CLK,
  input logic            RST,
  mult_acc_pipe_if.slave bus
);

  localparam int P_W = A_W + B_W;

  if (ACC_W < P_W) begin : g_bad_acc_w
    $error("mult_acc_pipe: ACC_W must be at least A_W + B_W");
  end
  if (ACC_W >= MAX_W) begin : g_bad_max_w
    $error("mult_acc_pipe: ACC_W exceeds the package working width");
  end

  ctrl_t            in_ctrl;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [ACC_W-1:0] s1_c;
  ctrl_t            s1_ctrl;
  logic [P_W-1:0]   a_x;
  logic [P_W-1:0]   b_x;
  logic [P_W-1:0]   prod_raw;
  logic [ACC_W-1:0] prod_ext;
  logic             prod_sgn;
  logic [ACC_W-1:0] s2_p;
  logic [ACC_W-1:0] s2_c;
  ctrl_t            s2_ctrl;

  always_comb begin
    in_ctrl        = '0;
    in_ctrl.vld    = bus.IN_VLD;
    in_ctrl.asgnd  = bus.ASGND;
    in_ctrl.bsgnd  = bus.BSGND;
    in_ctrl.addsub = bus.ADDSUB;
    in_ctrl.lda    = bus.LDA;
  end

  if (IN_REG != 0) begin : g_in_reg
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0] c_q, c_d;
    ctrl_t            ctrl_q, ctrl_d;

    always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      ctrl_d = ctrl_q;
      if (!bus.HLD) begin
        a_d    = bus.A;
        b_d    = bus.B;
        c_d    = bus.C;
        ctrl_d = in_ctrl;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        a_q    <= '0;
        b_q    <= '0;
        c_q    <= '0;
        ctrl_q <= '0;
      end else begin
        a_q    <= a_d;
        b_q    <= b_d;
        c_q    <= c_d;
        ctrl_q <= ctrl_d;
      end
    end

    assign s1_a    = a_q;
    assign s1_b    = b_q;
    assign s1_c    = c_q;
    assign s1_ctrl = ctrl_q;
  end else begin : g_in_bypass
    assign s1_a    = bus.A;
    assign s1_b    = bus.B;
    assign s1_c    = bus.C;
    assign s1_ctrl = in_ctrl;
  end

  // The exact product always fits in P_W bits, so a modulo-2^P_W multiply of the
  // properly extended operands is exact in every signedness mode.
  always_comb begin
    prod_sgn = s1_ctrl.asgnd | s1_ctrl.bsgnd;
    a_x      = {{B_W{s1_ctrl.asgnd & s1_a[A_W-1]}}, s1_a};
    b_x      = {{A_W{s1_ctrl.bsgnd & s1_b[B_W-1]}}, s1_b};
    prod_raw = a_x * b_x;
    prod_ext = ACC_W'(sign_ext(MAX_W'(prod_raw), P_W, prod_sgn));
  end

  if (MUL_REG != 0) begin : g_mul_reg
    logic [ACC_W-1:0] p_q, p_d;
    logic [ACC_W-1:0] c_q, c_d;
    ctrl_t            ctrl_q, ctrl_d;

    always_comb begin
      p_d    = p_q;
      c_d    = c_q;
      ctrl_d = ctrl_q;
      if (!bus.HLD) begin
        p_d    = prod_ext;
        c_d    = s1_c;
        ctrl_d = s1_ctrl;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        p_q    <= '0;
        c_q    <= '0;
        ctrl_q <= '0;
      end else begin
        p_q    <= p_d;
        c_q    <= c_d;
        ctrl_q <= ctrl_d;
      end
    end

    assign s2_p    = p_q;
    assign s2_c    = c_q;
    assign s2_ctrl = ctrl_q;
  end else begin : g_mul_bypass
    assign s2_p    = prod_ext;
    assign s2_c    = s1_c;
    assign s2_ctrl = s1_ctrl;
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_vld_q, out_vld_d;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_ovf;

  assign acc_base = s2_ctrl.lda ? s2_c : acc_q;

  mult_acc_satadd #(
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_satadd (
    .base_i    (acc_base),
    .operand_i (s2_p),
    .sub_i     (s2_ctrl.addsub),
    .sgnd_i    (s2_ctrl.asgnd | s2_ctrl.bsgnd),
    .result_o  (acc_sum),
    .ovf_o     (acc_ovf)
  );

  // OUT_VLD pulses per accumulated sample, so it stays low while held.
  // A loading sample restarts the sticky flag from its own overflow status.
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_vld_d = 1'b0;
    if (!bus.HLD && s2_ctrl.vld) begin
      acc_d     = acc_sum;
      out_vld_d = 1'b1;
      ovf_d     = s2_ctrl.lda ? acc_ovf : (ovf_q | acc_ovf);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.O       = acc_q;
  assign bus.OVF     = ovf_q;
  assign bus.OUT_VLD = out_vld_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed bench for mult_acc_pipe: four configurations share one stimulus
// stream and each step compares against hand-computed results.
module tb_mult_acc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [15:0] a;
  logic [15:0] b;
  logic [39:0] c;
  logic        asgnd;
  logic        bsgnd;
  logic        addsub;
  logic        lda;
  logic        hld;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_acc_pipe_if #(.A_W(16), .B_W(16), .ACC_W(40)) if_def ();
  mult_acc_pipe_if #(.A_W(16), .B_W(16), .ACC_W(32)) if_s32 ();
  mult_acc_pipe_if #(.A_W(16), .B_W(16), .ACC_W(32)) if_w32 ();
  mult_acc_pipe_if #(.A_W(16), .B_W(16), .ACC_W(40)) if_l1 ();

  assign if_def.IN_VLD = in_vld;
  assign if_def.A      = a;
  assign if_def.B      = b;
  assign if_def.C      = c;
  assign if_def.ASGND  = asgnd;
  assign if_def.BSGND  = bsgnd;
  assign if_def.ADDSUB = addsub;
  assign if_def.LDA    = lda;
  assign if_def.HLD    = hld;

  assign if_s32.IN_VLD = in_vld;
  assign if_s32.A      = a;
  assign if_s32.B      = b;
  assign if_s32.C      = c[31:0];
  assign if_s32.ASGND  = asgnd;
  assign if_s32.BSGND  = bsgnd;
  assign if_s32.ADDSUB = addsub;
  assign if_s32.LDA    = lda;
  assign if_s32.HLD    = hld;

  assign if_w32.IN_VLD = in_vld;
  assign if_w32.A      = a;
  assign if_w32.B      = b;
  assign if_w32.C      = c[31:0];
  assign if_w32.ASGND  = asgnd;
  assign if_w32.BSGND  = bsgnd;
  assign if_w32.ADDSUB = addsub;
  assign if_w32.LDA    = lda;
  assign if_w32.HLD    = hld;

  assign if_l1.IN_VLD = in_vld;
  assign if_l1.A      = a;
  assign if_l1.B      = b;
  assign if_l1.C      = c;
  assign if_l1.ASGND  = asgnd;
  assign if_l1.BSGND  = bsgnd;
  assign if_l1.ADDSUB = addsub;
  assign if_l1.LDA    = lda;
  assign if_l1.HLD    = hld;

  mult_acc_pipe u_def (.CLK(clk), .RST(rst), .bus(if_def));

  mult_acc_pipe #(.ACC_W(32), .SAT_EN(1)) u_s32 (.CLK(clk), .RST(rst), .bus(if_s32));

  mult_acc_pipe #(.ACC_W(32), .SAT_EN(0)) u_w32 (.CLK(clk), .RST(rst), .bus(if_w32));

  mult_acc_pipe #(.IN_REG(0), .MUL_REG(0)) u_l1 (.CLK(clk), .RST(rst), .bus(if_l1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                               input logic [39:0] cv, input logic sa, input logic sb,
                               input logic sub, input logic ld);
    in_vld = v;
    a      = av;
    b      = bv;
    c      = cv;
    asgnd  = sa;
    bsgnd  = sb;
    addsub = sub;
    lda    = ld;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'd0, 16'd0, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    hld = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic        exp_vld;
    logic [63:0] exp_o;
    logic [63:0] exp_w;
    logic        exp_ovf;

    rst = 1'b1;
    hld = 1'b0;
    idle();
    tick();
    tick();
    checkOutput("rst_o", 64'(if_def.O), 64'd0);
    checkBit("rst_vld", if_def.OUT_VLD, 1'b0);
    checkBit("rst_ovf", if_def.OVF, 1'b0);
    checkOutput("rst_l1_o", 64'(if_l1.O), 64'd0);
    rst = 1'b0;

    $display("[TB] single signed sample with load");
    applyStimulus(1'b1, 16'd3, 16'hFFFC, 40'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkBit("t1_l1_vld", if_l1.OUT_VLD, 1'b1);
    checkOutput("t1_l1_o", 64'(if_l1.O), 64'h00FF_FFFF_FFFE);
    checkBit("t1_vld_c1", if_def.OUT_VLD, 1'b0);
    idle();
    tick();
    checkBit("t1_vld_c2", if_def.OUT_VLD, 1'b0);
    tick();
    checkBit("t1_vld", if_def.OUT_VLD, 1'b1);
    checkOutput("t1_o", 64'(if_def.O), 64'h00FF_FFFF_FFFE);
    checkBit("t1_ovf", if_def.OVF, 1'b0);

    $display("[TB] back-to-back signed stream");
    for (int i = 0; i < 7; i++) begin
      if (i < 4) applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 40'd0, 1'b1, 1'b1, 1'b0, (i == 0));
      else idle();
      tick();
      if (i >= 2 && i <= 5) begin
        checkBit($sformatf("t2_vld_%0d", i), if_def.OUT_VLD, 1'b1);
        checkOutput($sformatf("t2_o_%0d", i), 64'(if_def.O), 64'(i - 1) * 64'h3FFF_0001);
      end else if (i == 6) begin
        checkBit("t2_vld_end", if_def.OUT_VLD, 1'b0);
        checkOutput("t2_o_end", 64'(if_def.O), 64'h00FF_FC00_04);
        checkBit("t2_ovf", if_def.OVF, 1'b0);
      end
    end

    $display("[TB] 32-bit signed saturation and wrap, then clearing load");
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 40'd0, 1'b1, 1'b1, 1'b0, (i == 0));
      else if (i == 3) applyStimulus(1'b1, 16'h0000, 16'h7FFF, 40'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      else idle();
      tick();
      if (i >= 2) begin
        case (i)
          2:       begin exp_o = 64'h3FFF_0001; exp_w = 64'h3FFF_0001; exp_ovf = 1'b0; end
          3:       begin exp_o = 64'h7FFE_0002; exp_w = 64'h7FFE_0002; exp_ovf = 1'b0; end
          4:       begin exp_o = 64'h7FFF_FFFF; exp_w = 64'hBFFD_0003; exp_ovf = 1'b1; end
          default: begin exp_o = 64'h0;         exp_w = 64'h0;         exp_ovf = 1'b0; end
        endcase
        checkBit($sformatf("t3_vld_%0d", i), if_s32.OUT_VLD, 1'b1);
        checkOutput($sformatf("t3_sat_o_%0d", i), 64'(if_s32.O), exp_o);
        checkBit($sformatf("t3_sat_ovf_%0d", i), if_s32.OVF, exp_ovf);
        checkOutput($sformatf("t3_wrap_o_%0d", i), 64'(if_w32.O), exp_w);
        checkBit($sformatf("t3_wrap_ovf_%0d", i), if_w32.OVF, exp_ovf);
      end
    end

    $display("[TB] unsigned borrow, sticky flag, mixed signedness");
    doReset();
    applyStimulus(1'b1, 16'd2, 16'd3, 40'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    tick();
    checkBit("t4_vld", if_s32.OUT_VLD, 1'b1);
    checkOutput("t4_sat_o", 64'(if_s32.O), 64'h0);
    checkBit("t4_sat_ovf", if_s32.OVF, 1'b1);
    checkOutput("t4_wrap_o", 64'(if_w32.O), 64'hFFFF_FFFF);
    checkBit("t4_wrap_ovf", if_w32.OVF, 1'b1);
    checkOutput("t4_def_o", 64'(if_def.O), 64'h0);
    checkBit("t4_def_ovf", if_def.OVF, 1'b1);
    applyStimulus(1'b1, 16'd0, 16'd0, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    checkBit("t4_sticky_vld", if_s32.OUT_VLD, 1'b1);
    checkBit("t4_sticky_ovf", if_s32.OVF, 1'b1);
    checkOutput("t4_sticky_o", 64'(if_s32.O), 64'h0);
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 40'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    tick();
    checkOutput("t4_mixed_o", 64'(if_def.O), 64'h00FF_FFFF_0001);
    checkBit("t4_mixed_ovf", if_def.OVF, 1'b0);

    $display("[TB] two-cycle hold in the middle of a stream");
    doReset();
    for (int i = 0; i < 9; i++) begin
      hld = (i == 3 || i == 4);
      case (i)
        0:       applyStimulus(1'b1, 16'd1,   16'd1, 40'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        1:       applyStimulus(1'b1, 16'd2,   16'd1, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        2:       applyStimulus(1'b1, 16'd3,   16'd1, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        3, 4:    applyStimulus(1'b1, 16'd100, 16'd1, 40'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        5:       applyStimulus(1'b1, 16'd4,   16'd1, 40'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        default: idle();
      endcase
      tick();
      case (i)
        0, 1:    begin exp_vld = 1'b0; exp_o = 64'd0;  end
        2:       begin exp_vld = 1'b1; exp_o = 64'd1;  end
        3, 4:    begin exp_vld = 1'b0; exp_o = 64'd1;  end
        5:       begin exp_vld = 1'b1; exp_o = 64'd3;  end
        6:       begin exp_vld = 1'b1; exp_o = 64'd6;  end
        7:       begin exp_vld = 1'b1; exp_o = 64'd10; end
        default: begin exp_vld = 1'b0; exp_o = 64'd10; end
      endcase
      checkBit($sformatf("t5_vld_%0d", i), if_def.OUT_VLD, exp_vld);
      checkOutput($sformatf("t5_o_%0d", i), 64'(if_def.O), exp_o);
    end
    hld = 1'b0;

    $display("[TB] minimum latency and reset with samples in flight");
    doReset();
    applyStimulus(1'b1, 16'd2, 16'd2, 40'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkBit("t6_l1_vld", if_l1.OUT_VLD, 1'b1);
    checkOutput("t6_l1_o", 64'(if_l1.O), 64'd5);
    idle();
    tick();
    checkBit("t6_l1_vld_end", if_l1.OUT_VLD, 1'b0);
    checkOutput("t6_l1_o_hold", 64'(if_l1.O), 64'd5);

    doReset();
    applyStimulus(1'b1, 16'd1, 16'd1, 40'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBit($sformatf("t6_flush_vld_%0d", i), if_def.OUT_VLD, 1'b0);
      checkOutput($sformatf("t6_flush_o_%0d", i), 64'(if_def.O), 64'd0);
    end
    applyStimulus(1'b1, 16'd2, 16'd3, 40'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    checkBit("t6_recover_early", if_def.OUT_VLD, 1'b0);
    tick();
    checkBit("t6_recover_vld", if_def.OUT_VLD, 1'b1);
    checkOutput("t6_recover_o", 64'(if_def.O), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
